// File: rtl/adc_frame_packer_if.sv
// rtl/adc_frame_packer_if.sv - framed 32-bit output stream between packer and DMA stage
interface adc_frame_packer_if;
  logic [31:0] m_data_o;
  logic        m_valid_o;
  logic        m_ready_i;
  logic        m_last_o;

  modport master (output m_data_o, output m_valid_o, output m_last_o, input m_ready_i);
  modport slave  (input m_data_o, input m_valid_o, input m_last_o, output m_ready_i);
endinterface

// File: rtl/adc_frame_packer.sv
// rtl/adc_frame_packer.sv - snapshots one ADC sample set per strobe and streams it as a 14-word frame
module adc_frame_packer #(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter logic [7:0]  HEADER_TAG = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable_i,
  input  logic                          sample_valid_i,
  input  logic [31:0]                   adc_shear1_i,
  input  logic [31:0]                   adc_shear2_i,
  input  logic [31:0]                   adc_shear3_i,
  input  logic [31:0]                   adc_shear4_i,
  input  logic [31:0]                   adc_point1_i,
  input  logic [31:0]                   adc_point2_i,
  input  logic [31:0]                   adc_point3_i,
  input  logic [31:0]                   adc_point4_i,
  input  logic [31:0]                   adc_sine_ref_i,
  input  logic [31:0]                   adc_opd_ref_i,
  input  logic [31:0]                   opd_x_i,
  input  logic [31:0]                   opd_y_i,
  input  logic [31:0]                   osync_i,
  adc_frame_packer_if.master            m,
  output logic [$clog2(FIFO_DEPTH):0]   fill_o,
  output logic [15:0]                   drop_count_o,
  output logic [23:0]                   seq_o
);

  localparam int AW          = $clog2(FIFO_DEPTH);
  localparam int FILL_W      = AW + 1;
  localparam int FRAME_WORDS = 14;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t            state, state_nxt;
  logic [3:0]        word_idx;
  logic [31:0]       frame [FRAME_WORDS];
  logic [23:0]       seq;
  logic [15:0]       drop_count;
  logic              accept, drop, wr_en, wr_last, space_ok;
  logic [31:0]       wr_data;

  logic [32:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [FILL_W-1:0] fill;
  logic              out_valid, out_last;
  logic [31:0]       out_data;
  logic              pop, load_out, mem_empty, from_mem, bypass, mem_push;

  // Space is judged on registered fill only; a read in the strobe cycle does not count.
  assign space_ok = fill <= FILL_W'(FIFO_DEPTH - FRAME_WORDS);
  assign wr_data  = frame[word_idx];

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    drop      = 1'b0;
    wr_en     = 1'b0;
    wr_last   = 1'b0;
    case (state)
      IDLE: begin
        if (sample_valid_i && enable_i) begin
          if (space_ok) begin
            accept    = 1'b1;
            state_nxt = WRITE;
          end else begin
            drop = 1'b1;
          end
        end
      end
      WRITE: begin
        wr_en   = 1'b1;
        wr_last = (word_idx == 4'(FRAME_WORDS - 1));
        drop    = sample_valid_i && enable_i;
        if (wr_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      word_idx   <= '0;
      seq        <= '0;
      drop_count <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        word_idx <= '0;
        seq      <= seq + 24'd1;
      end else if (state == WRITE) begin
        word_idx <= word_idx + 4'd1;
      end
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      frame[0]  <= {HEADER_TAG, seq};
      frame[1]  <= adc_shear1_i;
      frame[2]  <= adc_shear2_i;
      frame[3]  <= adc_shear3_i;
      frame[4]  <= adc_shear4_i;
      frame[5]  <= adc_point1_i;
      frame[6]  <= adc_point2_i;
      frame[7]  <= adc_point3_i;
      frame[8]  <= adc_point4_i;
      frame[9]  <= adc_sine_ref_i;
      frame[10] <= adc_opd_ref_i;
      frame[11] <= opd_x_i;
      frame[12] <= opd_y_i;
      frame[13] <= osync_i;
    end
  end

  // fill includes the output register, so the memory is empty when fill equals out_valid.
  assign pop       = out_valid && m.m_ready_i;
  assign load_out  = !out_valid || pop;
  assign mem_empty = (fill == FILL_W'(out_valid));
  assign from_mem  = load_out && !mem_empty;
  assign bypass    = load_out && mem_empty && wr_en;
  assign mem_push  = wr_en && !bypass;

  always_ff @(posedge clk) begin
    if (mem_push) mem[wr_ptr] <= {wr_last, wr_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      fill <= fill + FILL_W'(wr_en) - FILL_W'(pop);
      if (mem_push) wr_ptr <= wr_ptr + 1'b1;
      if (from_mem) begin
        {out_last, out_data} <= mem[rd_ptr];
        rd_ptr               <= rd_ptr + 1'b1;
        out_valid            <= 1'b1;
      end else if (bypass) begin
        {out_last, out_data} <= {wr_last, wr_data};
        out_valid            <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign m.m_data_o   = out_data;
  assign m.m_valid_o  = out_valid;
  assign m.m_last_o   = out_last;
  assign fill_o       = fill;
  assign drop_count_o = drop_count;
  assign seq_o        = seq;

endmodule

// File: tb/tb_adc_frame_packer.sv
// tb/tb_adc_frame_packer.sv - self-checking bench for adc_frame_packer
module tb_adc_frame_packer;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        sample_valid;
  logic [31:0] smp [13];
  logic [6:0]  fill;
  logic [15:0] drop_count;
  logic [23:0] seq;

  always #5 clk = ~clk;

  adc_frame_packer_if bus ();

  adc_frame_packer #(.FIFO_DEPTH(DEPTH), .HEADER_TAG(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .sample_valid_i(sample_valid),
    .adc_shear1_i(smp[0]), .adc_shear2_i(smp[1]), .adc_shear3_i(smp[2]), .adc_shear4_i(smp[3]),
    .adc_point1_i(smp[4]), .adc_point2_i(smp[5]), .adc_point3_i(smp[6]), .adc_point4_i(smp[7]),
    .adc_sine_ref_i(smp[8]), .adc_opd_ref_i(smp[9]), .opd_x_i(smp[10]), .opd_y_i(smp[11]),
    .osync_i(smp[12]), .m(bus), .fill_o(fill), .drop_count_o(drop_count), .seq_o(seq)
  );

  logic [32:0] exp_q  [$];
  logic [32:0] pend_q [$];
  int unsigned m_seq, m_drop;
  int          n_reads, n_lasts;
  int          total, bad;
  logic        rand_data;

  typedef struct {
    int   n;
    int   gap;
    logic en;
    logic rdy;
    int   exp_fill;
    int   exp_drop;
    int   exp_seq;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    pend_q.delete();
    m_seq   = 0;
    m_drop  = 0;
    n_reads = 0;
    n_lasts = 0;
  endtask

  task automatic check_state();
    chk("valid", bus.m_valid_o, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      chk("data", bus.m_data_o, exp_q[0][31:0]);
      chk("last", bus.m_last_o, exp_q[0][32]);
    end
    chk("fill", fill, exp_q.size());
    chk("seq", seq, m_seq[23:0]);
    chk("drop", drop_count, m_drop);
  endtask

  // Frame-level model: one pending frame drains one word per cycle into the output queue.
  task automatic model_update();
    bit          pop;
    bit          idle;
    int unsigned fill_now;
    logic [32:0] w;
    pop      = (exp_q.size() > 0) && bus.m_ready_i;
    idle     = (pend_q.size() == 0);
    fill_now = exp_q.size();
    if (!idle) exp_q.push_back(pend_q.pop_front());
    if (pop) begin
      w = exp_q.pop_front();
      n_reads++;
      if (w[32]) n_lasts++;
    end
    if (sample_valid && enable) begin
      if (idle && (DEPTH - fill_now >= 14)) begin
        pend_q.push_back({1'b0, 8'hA5, m_seq[23:0]});
        for (int i = 0; i < 13; i++) pend_q.push_back({i == 12, smp[i]});
        m_seq = (m_seq + 1) % (1 << 24);
      end else if (m_drop < 16'hFFFF) begin
        m_drop++;
      end
    end
  endtask

  task automatic step(input logic s, input logic en, input logic rdy);
    check_state();
    sample_valid  = s;
    enable        = en;
    bus.m_ready_i = rdy;
    if (rand_data) for (int i = 0; i < 13; i++) smp[i] = $urandom;
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    sample_valid  = 1'b0;
    enable        = 1'b0;
    bus.m_ready_i = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int words;
    int hdrs;
    int cyc;
    total = 0;
    bad   = 0;
    rand_data = 1'b0;
    for (int i = 0; i < 13; i++) smp[i] = '0;

    vecs[0] = '{n: 4, gap: 20, en: 1'b1, rdy: 1'b0, exp_fill: 56, exp_drop: 0, exp_seq: 4};
    vecs[1] = '{n: 5, gap: 20, en: 1'b1, rdy: 1'b0, exp_fill: 56, exp_drop: 1, exp_seq: 4};
    vecs[2] = '{n: 2, gap: 5,  en: 1'b1, rdy: 1'b0, exp_fill: 14, exp_drop: 1, exp_seq: 1};
    vecs[3] = '{n: 3, gap: 20, en: 1'b0, rdy: 1'b0, exp_fill: 0,  exp_drop: 0, exp_seq: 0};
    vecs[4] = '{n: 1, gap: 20, en: 1'b1, rdy: 1'b1, exp_fill: 0,  exp_drop: 0, exp_seq: 1};
    vecs[5] = '{n: 2, gap: 14, en: 1'b1, rdy: 1'b0, exp_fill: 14, exp_drop: 1, exp_seq: 1};
    vecs[6] = '{n: 2, gap: 15, en: 1'b1, rdy: 1'b0, exp_fill: 28, exp_drop: 0, exp_seq: 2};

    @(negedge clk);
    do_reset();
    chk("rst_valid", bus.m_valid_o, 0);
    chk("rst_last", bus.m_last_o, 0);
    chk("rst_data", bus.m_data_o, 0);
    chk("rst_fill", fill, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_seq", seq, 0);

    // Single frame with known channel values: latency and framing.
    for (int i = 0; i < 8; i++) smp[i] = {8{4'(i + 1)}};
    smp[8]  = 32'h99999999;
    smp[9]  = 32'hAAAAAAAA;
    smp[10] = 32'hBBBBBBBB;
    smp[11] = 32'hCCCCCCCC;
    smp[12] = 32'h0000ABCD;
    step(1'b1, 1'b1, 1'b1);
    chk("lat_c1_valid", bus.m_valid_o, 0);
    for (int k = 0; k < 14; k++) begin
      step(1'b0, 1'b1, 1'b1);
      chk("stream_valid", bus.m_valid_o, 1);
      if (k == 0) chk("first_word", bus.m_data_o, 32'hA5000000);
      if (k == 13) begin
        chk("last_word", bus.m_data_o, 32'h0000ABCD);
        chk("last_flag", bus.m_last_o, 1);
      end else begin
        chk("not_last", bus.m_last_o, 0);
      end
    end
    step(1'b0, 1'b1, 1'b1);
    chk("after_frame_valid", bus.m_valid_o, 0);
    chk("seq_one", seq, 1);

    rand_data = 1'b1;
    foreach (vecs[v]) begin
      do_reset();
      for (int s = 0; s < vecs[v].n; s++) begin
        step(1'b1, vecs[v].en, vecs[v].rdy);
        repeat (vecs[v].gap - 1) step(1'b0, vecs[v].en, vecs[v].rdy);
      end
      repeat (20) step(1'b0, vecs[v].en, vecs[v].rdy);
      chk($sformatf("vec%0d_fill", v), fill, vecs[v].exp_fill);
      chk($sformatf("vec%0d_drop", v), drop_count, vecs[v].exp_drop);
      chk($sformatf("vec%0d_seq", v), seq, vecs[v].exp_seq);
    end

    // Four buffered frames drain with headers in sequence order.
    do_reset();
    for (int s = 0; s < 4; s++) begin
      step(1'b1, 1'b1, 1'b0);
      repeat (19) step(1'b0, 1'b1, 1'b0);
    end
    words = 0;
    hdrs  = 0;
    for (int c = 0; c < 200 && words < 56; c++) begin
      if (bus.m_valid_o) begin
        if (words % 14 == 0) begin
          chk($sformatf("hdr%0d", hdrs), bus.m_data_o, {8'hA5, 24'(hdrs)});
          hdrs++;
        end
        words++;
      end
      step(1'b0, 1'b1, 1'b1);
    end
    chk("hdr_count", hdrs, 4);

    // Random strobes and backpressure against the model.
    do_reset();
    cyc = 0;
    while (m_seq < 200 && cyc < 20000) begin
      step($urandom_range(0, 11) == 0, 1'b1, $urandom_range(0, 9) < 7);
      cyc++;
    end
    chk("rand_frames_done", m_seq >= 200, 1);
    repeat (100) step(1'b0, 1'b1, 1'b1);
    chk("rand_drained", fill, 0);
    chk("rand_words", n_reads, 200 * 14);
    chk("rand_lasts", n_lasts * 14, n_reads);

    // Asynchronous reset in the middle of a frame.
    do_reset();
    step(1'b1, 1'b1, 1'b1);
    repeat (5) step(1'b0, 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_valid", bus.m_valid_o, 0);
    chk("async_fill", fill, 0);
    chk("async_seq", seq, 0);
    model_clear();
    sample_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk("post_rst_valid", bus.m_valid_o, 1);
    chk("post_rst_hdr", bus.m_data_o, 32'hA5000000);
    repeat (16) step(1'b0, 1'b1, 1'b1);

    // Drop counter saturation.
    do_reset();
    force dut.drop_count = 16'hFFFE;
    m_drop = 16'hFFFE;
    #1;
    release dut.drop_count;
    @(negedge clk);
    step(1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("drop_saturate", drop_count, 16'hFFFF);
    chk("sat_seq", seq, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
